// File: rtl/morse_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : morse_sequencer
//  Description : Keys one Morse letter at a time. A symbol (element pattern
//                plus length) is accepted over a valid/ready handshake, and
//                each dot (1 unit), dash (3 units), inter-element gap
//                (1 unit) and letter gap (3 units) is timed by one shared
//                unit/cycle counter pair.
//  Ports       : clock        - system clock, rising edge
//                reset        - asynchronous, active-high reset
//                sym_valid    - symbol offered
//                sym_ready    - sequencer idle, symbol can be taken
//                sym_pattern  - bit i = element i (1=dash, 0=dot), bit 0 first
//                sym_len      - element count 1..MAX_LEN, 0 = word-space request
//                key          - registered tone gate, 1 = tone on
//                busy         - 1 while a symbol is in progress
//                letter_done  - one-cycle pulse when a symbol completes
//  Options     : MORSE_WORD_GAP_EN - when defined, a word-space request holds
//                the line quiet for 4 units; otherwise it completes at once.
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_sequencer #(
    parameter int MAX_LEN  = 5,
    parameter int UNIT_CYC = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sym_valid,
    output logic               sym_ready,
    input  logic [MAX_LEN-1:0] sym_pattern,
    input  logic [2:0]         sym_len,
    output logic               key,
    output logic               busy,
    output logic               letter_done
);

    localparam int CW = $clog2(7 * UNIT_CYC + 1);

    // Counters hold "remaining minus one": a phase of N units loads N-1 into
    // the unit counter and UNIT_CYC-1 into the cycle counter, exiting at 0/0.
    localparam logic [CW-1:0] c_cyc_load  = CW'(UNIT_CYC - 1);
    localparam logic [CW-1:0] c_unit_dot  = CW'(0);
    localparam logic [CW-1:0] c_unit_dash = CW'(2);
    localparam logic [CW-1:0] c_unit_gap  = CW'(0);
    localparam logic [CW-1:0] c_unit_lgap = CW'(2);
`ifdef MORSE_WORD_GAP_EN
    localparam logic [CW-1:0] c_unit_wgap = CW'(3);
    localparam logic [CW-1:0] c_cyc_wgap  = c_cyc_load;
`else
    // A single-cycle WGAP: busy for one cycle, then letter_done.
    localparam logic [CW-1:0] c_unit_wgap = CW'(0);
    localparam logic [CW-1:0] c_cyc_wgap  = CW'(0);
`endif
    localparam logic [2:0]    c_max_len   = 3'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MARK = 3'd1,
        S_GAP  = 3'd2,
        S_LGAP = 3'd3,
        S_WGAP = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_unit_cnt, w_unit_nxt;
    logic [CW-1:0]      r_cyc_cnt, w_cyc_nxt;
    logic [MAX_LEN-1:0] r_pat, w_pat_nxt;
    logic [2:0]         r_remain, w_remain_nxt;   // elements left after current
    logic               w_key_nxt;
    logic               w_done_nxt;

    logic               w_fire;
    logic               w_cnt_zero;
    logic [2:0]         w_len_clamped;
    logic [MAX_LEN-1:0] w_pat_shift;

    assign sym_ready     = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign w_fire        = sym_valid & sym_ready;
    assign w_cnt_zero    = (r_unit_cnt == '0) && (r_cyc_cnt == '0);
    assign w_len_clamped = (sym_len > c_max_len) ? c_max_len : sym_len;
    assign w_pat_shift   = r_pat >> 1;

    always_comb begin
        w_state_nxt  = r_state;
        w_unit_nxt   = r_unit_cnt;
        w_cyc_nxt    = r_cyc_cnt;
        w_pat_nxt    = r_pat;
        w_remain_nxt = r_remain;
        w_done_nxt   = 1'b0;

        // Free-running countdown within a phase; saturates at 0/0 so it never wraps.
        if (r_cyc_cnt != '0) begin
            w_cyc_nxt = r_cyc_cnt - CW'(1);
        end else if (r_unit_cnt != '0) begin
            w_unit_nxt = r_unit_cnt - CW'(1);
            w_cyc_nxt  = c_cyc_load;
        end

        case (r_state)
            S_IDLE: begin
                if (w_fire) begin
                    if (w_len_clamped == 3'd0) begin
                        w_state_nxt = S_WGAP;
                        w_unit_nxt  = c_unit_wgap;
                        w_cyc_nxt   = c_cyc_wgap;
                        w_pat_nxt   = '0;
                        w_remain_nxt = 3'd0;
                    end else begin
                        w_state_nxt  = S_MARK;
                        w_pat_nxt    = sym_pattern;
                        w_remain_nxt = w_len_clamped - 3'd1;
                        w_unit_nxt   = sym_pattern[0] ? c_unit_dash : c_unit_dot;
                        w_cyc_nxt    = c_cyc_load;
                    end
                end
            end
            S_MARK: begin
                if (w_cnt_zero) begin
                    w_cyc_nxt = c_cyc_load;
                    if (r_remain == 3'd0) begin
                        w_state_nxt = S_LGAP;
                        w_unit_nxt  = c_unit_lgap;
                    end else begin
                        w_state_nxt = S_GAP;
                        w_unit_nxt  = c_unit_gap;
                    end
                end
            end
            S_GAP: begin
                if (w_cnt_zero) begin
                    // Advance to the next element: its type is the new bit 0.
                    w_state_nxt  = S_MARK;
                    w_pat_nxt    = w_pat_shift;
                    w_remain_nxt = r_remain - 3'd1;
                    w_unit_nxt   = w_pat_shift[0] ? c_unit_dash : c_unit_dot;
                    w_cyc_nxt    = c_cyc_load;
                end
            end
            S_LGAP, S_WGAP: begin
                if (w_cnt_zero) begin
                    w_state_nxt  = S_IDLE;
                    w_done_nxt   = 1'b1;
                    w_pat_nxt    = '0;
                    w_remain_nxt = 3'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_unit_nxt  = '0;
                w_cyc_nxt   = '0;
            end
        endcase

        // Key is registered alongside the state so it tracks MARK exactly.
        w_key_nxt = (w_state_nxt == S_MARK);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_unit_cnt  <= '0;
            r_cyc_cnt   <= '0;
            r_pat       <= '0;
            r_remain    <= 3'd0;
            key         <= 1'b0;
            letter_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_unit_cnt  <= w_unit_nxt;
            r_cyc_cnt   <= w_cyc_nxt;
            r_pat       <= w_pat_nxt;
            r_remain    <= w_remain_nxt;
            key         <= w_key_nxt;
            letter_done <= w_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_morse_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_morse_sequencer
//  Description : Self-checking bench for morse_sequencer (MAX_LEN=5,
//                UNIT_CYC=4). A queue-based timeline model predicts key/busy/
//                ready/letter_done every cycle; directed letters pin the
//                model with hand-computed cycle numbers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_sequencer;

    localparam int U = 4;
    localparam int ML = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          sym_valid = 1'b0;
    logic          sym_ready;
    logic [ML-1:0] sym_pattern = '0;
    logic [2:0]    sym_len = 3'd0;
    logic          key;
    logic          busy;
    logic          letter_done;

    int n_checks = 0;
    int n_fail   = 0;

    morse_sequencer #(.MAX_LEN(ML), .UNIT_CYC(U)) dut (
        .clock       (clock),
        .reset       (reset),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .sym_pattern (sym_pattern),
        .sym_len     (sym_len),
        .key         (key),
        .busy        (busy),
        .letter_done (letter_done)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Timeline model: one queue entry per future busy cycle, holding the
    // expected key level. Empty queue = idle.
    // ------------------------------------------------------------------
    bit exp_q[$];
    bit m_done = 1'b0;

    function automatic void push_symbol(logic [ML-1:0] p, logic [2:0] l);
        int n;
        n = (int'(l) > ML) ? ML : int'(l);
        if (n == 0) begin
`ifdef MORSE_WORD_GAP_EN
            for (int c = 0; c < 4 * U; c++) exp_q.push_back(1'b0);
`else
            exp_q.push_back(1'b0);
`endif
        end else begin
            for (int i = 0; i < n; i++) begin
                for (int c = 0; c < (p[i] ? 3 * U : U); c++) exp_q.push_back(1'b1);
                if (i < n - 1)
                    for (int c = 0; c < U; c++) exp_q.push_back(1'b0);
            end
            for (int c = 0; c < 3 * U; c++) exp_q.push_back(1'b0);
        end
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_done <= 1'b0;
        end else if (exp_q.size() != 0) begin
            m_done <= (exp_q.size() == 1);
            exp_q.pop_front();
        end else begin
            m_done <= 1'b0;
            if (sym_valid) push_symbol(sym_pattern, sym_len);
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clock) begin
        logic [3:0] exp_v, act_v;
        exp_v = {(exp_q.size() != 0) ? exp_q[0] : 1'b0,
                 exp_q.size() != 0, exp_q.size() == 0, m_done};
        act_v = {key, busy, sym_ready, letter_done};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL model_cycle t=%0t {key,busy,ready,done} got %b expected %b",
                     $time, act_v, exp_v);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    bit key_log [0:255];
    int done_at;

    // Offer a symbol from idle, log key per cycle (cycle 1 = first after
    // transfer edge) until letter_done or the cycle budget runs out.
    task automatic run_sym(input logic [ML-1:0] p, input logic [2:0] l,
                           input int exp_done, input string nm);
        for (int i = 0; i < 256; i++) key_log[i] = 1'b0;
        done_at = -1;
        @(negedge clock);
        sym_pattern = p;
        sym_len     = l;
        sym_valid   = 1'b1;
        @(posedge clock);
        for (int n = 1; n < 200; n++) begin
            @(negedge clock);
            if (n == 1) begin
                sym_valid   = 1'b0;
                sym_pattern = '1;   // must be ignored after capture
                sym_len     = 3'd3;
            end
            key_log[n] = key;
            if (letter_done) begin
                done_at = n;
                chk({nm, "_ready_at_done"}, int'(sym_ready), 1);
                break;
            end
        end
        chk({nm, "_done_cycle"}, done_at, exp_done);
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_key", int'(key), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ready", int'(sym_ready), 1);
        chk("reset_done", int'(letter_done), 0);
        reset = 1'b0;

        // 1: 'E'
        run_sym(5'b00000, 3'd1, 17, "E");
        chk("E_key_c1", int'(key_log[1]), 1);
        chk("E_key_c4", int'(key_log[4]), 1);
        chk("E_key_c5", int'(key_log[5]), 0);
        chk("E_key_c16", int'(key_log[16]), 0);

        // 2: 'A' = dot dash
        run_sym(5'b00010, 3'd2, 33, "A");
        chk("A_key_c4", int'(key_log[4]), 1);
        chk("A_key_c8", int'(key_log[8]), 0);
        chk("A_key_c9", int'(key_log[9]), 1);
        chk("A_key_c20", int'(key_log[20]), 1);
        chk("A_key_c21", int'(key_log[21]), 0);

        // 3: len 7 clamps to 5 dashes
        run_sym(5'b11111, 3'd7, 89, "clamp");
        chk("clamp_key_c12", int'(key_log[12]), 1);
        chk("clamp_key_c13", int'(key_log[13]), 0);
        chk("clamp_key_c17", int'(key_log[17]), 1);
        chk("clamp_key_c76", int'(key_log[76]), 1);
        chk("clamp_key_c77", int'(key_log[77]), 0);

        // 4: 'T' aborted by reset in cycle 6
        @(negedge clock);
        sym_pattern = 5'b00001;
        sym_len     = 3'd1;
        sym_valid   = 1'b1;
        @(posedge clock);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clock);
            if (n == 1) sym_valid = 1'b0;
        end
        chk("T_key_c5", int'(key), 1);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("abort_key_async", int'(key), 0);
        chk("abort_ready", int'(sym_ready), 1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (letter_done) seen++;
        end
        chk("abort_no_done", seen, 0);
        run_sym(5'b00000, 3'd1, 17, "E_after_rst");

        // 5: held valid, 'E' then 'T' back-to-back
        for (int i = 0; i < 256; i++) key_log[i] = 1'b0;
        done_at = -1;
        @(negedge clock);
        sym_pattern = 5'b00000;
        sym_len     = 3'd1;
        sym_valid   = 1'b1;
        @(posedge clock);
        for (int n = 1; n < 60; n++) begin
            @(negedge clock);
            if (n == 1) begin
                sym_pattern = 5'b00001;
                sym_len     = 3'd1;
            end
            if (n == 18) sym_valid = 1'b0;
            key_log[n] = key;
            if (letter_done && done_at < 0) done_at = n;
            if (n == 31) break;
        end
        chk("b2b_E_done", done_at, 17);
        chk("b2b_T_key_c17", int'(key_log[17]), 0);
        chk("b2b_T_key_c18", int'(key_log[18]), 1);
        chk("b2b_T_key_c29", int'(key_log[29]), 1);
        chk("b2b_T_key_c30", int'(key_log[30]), 0);
        done_at = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (letter_done) begin
                done_at = n;
                break;
            end
        end
        chk("b2b_T_finished", int'(done_at >= 0), 1);

        // 6: word-space request
`ifdef MORSE_WORD_GAP_EN
        run_sym(5'b00000, 3'd0, 17, "word");
`else
        run_sym(5'b00000, 3'd0, 2, "word");
`endif
        seen = 0;
        for (int i = 0; i < 256; i++) if (key_log[i]) seen++;
        chk("word_key_quiet", seen, 0);

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
